// File: rtl/lsu_mem_stage.sv
// RV32I memory-stage load/store unit: one req/gnt/rvalid transaction per op, with store lane alignment and load extraction.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_we,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_misalign,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // funct3[1:0] alone picks the access size; the unused encodings fall into word
  function automatic logic [1:0] op_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   op_size = SZ_B;
      2'b01:   op_size = SZ_H;
      default: op_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (op_size(f3))
      SZ_B:    store_be = 4'b0001 << a;
      SZ_H:    store_be = 4'b0011 << {a[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (op_size(f3))
      SZ_B:    store_wdata = {4{d[7:0]}};
      SZ_H:    store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [31:0] sh;
    case (op_size(f3))
      SZ_B: begin
        sh = rd >> {a, 3'b000};
        load_extract = f3[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        sh = rd >> {a[1], 4'b0000};
        load_extract = f3[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        sh = rd;
        load_extract = sh;
      end
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [4:0]        rd_q, rd_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              wb_misalign_q, wb_misalign_d;
  logic              mis_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_s = ((op_size(ex_funct3) == SZ_H) && ex_addr[0]) ||
                 ((op_size(ex_funct3) == SZ_W) && (ex_addr[1:0] != 2'b00));
`else
  assign mis_s = 1'b0;
`endif

  // Next-state and output-register computation for the transaction FSM
  always_comb begin
    state_d       = state_q;
    addr_lo_d     = addr_lo_q;
    funct3_d      = funct3_q;
    we_d          = we_q;
    rd_d          = rd_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_be_d     = dmem_be_q;
    dmem_wdata_d  = dmem_wdata_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    wb_misalign_d = wb_misalign_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          addr_lo_d = ex_addr[1:0];
          funct3_d  = ex_funct3;
          we_d      = ex_we;
          rd_d      = ex_rd;
          if (mis_s) begin
            // Trapped op skips the bus entirely and completes next cycle
            state_d       = S_RESP;
            wb_valid_d    = 1'b1;
            wb_rd_d       = ex_rd;
            wb_data_d     = 32'h0000_0000;
            wb_misalign_d = 1'b1;
          end else begin
            state_d      = S_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_we;
            dmem_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
            dmem_be_d    = ex_we ? store_be(ex_funct3, ex_addr[1:0]) : 4'b1111;
            dmem_wdata_d = ex_we ? store_wdata(ex_funct3, ex_wdata) : 32'h0000_0000;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (we_q) begin
            state_d       = S_RESP;
            wb_valid_d    = 1'b1;
            wb_rd_d       = rd_q;
            wb_data_d     = 32'h0000_0000;
            wb_misalign_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_d       = S_RESP;
          wb_valid_d    = 1'b1;
          wb_rd_d       = rd_q;
          wb_data_d     = load_extract(funct3_q, addr_lo_q, dmem_rdata);
          wb_misalign_d = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_lo_q     <= 2'b00;
      funct3_q      <= 3'b000;
      we_q          <= 1'b0;
      rd_q          <= 5'd0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_be_q     <= 4'b0000;
      dmem_wdata_q  <= 32'h0000_0000;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= 32'h0000_0000;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      funct3_q      <= funct3_d;
      we_q          <= we_d;
      rd_q          <= rd_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_be_q     <= dmem_be_d;
      dmem_wdata_q  <= dmem_wdata_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end

  assign ex_ready    = (state_q == S_IDLE);
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a behavioural memory-op model.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, ex_we;
  logic [31:0] ex_addr, ex_wdata;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        wb_valid, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_pass = 0;
  int n_total = 0;

  lsu_mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_we(ex_we), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (a % 32'd4) % size_bytes(f3) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // byte offset of the accessed lane inside the word
  function automatic int lane(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_bytes(f3);
    return int'(a % 32'd4) / sz * sz;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_bytes(f3);
    return 4'(((1 << sz) - 1) << lane(f3, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = size_bytes(f3);
    if (sz == 1) return (d % 32'd256) * 32'h0101_0101;
    if (sz == 2) return (d % 32'd65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz = size_bytes(f3);
    longint v, lim;
    if (sz == 4) return rd;
    lim = longint'(1) << (8 * sz);
    v = longint'(rd >> (8 * lane(f3, a))) % lim;
    if (f3[2] == 1'b0 && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // Present one op at the current (IDLE) negedge and follow it through completion.
  // Returns positioned at the IDLE negedge following RESP.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdat,
                        input int gd, input int rvd);
    logic [31:0] exp_wb;
    bit mis;
    mis = model_mis(f3, a);
    exp_wb = (we || mis) ? 32'h0 : model_load(f3, a, rdat);
    check("ready_idle", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
    ex_funct3 = 3'($urandom); ex_we = 1'($urandom);
    if (!mis) begin
      for (int k = 0; k <= gd; k++) begin
        @(negedge clk);
        check("req", 32'(dmem_req), 32'd1);
        check("req_we", 32'(dmem_we), 32'(we));
        check("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
        check("req_be", 32'(dmem_be), we ? 32'(model_be(f3, a)) : 32'hF);
        if (we) check("req_wdata", dmem_wdata, model_wdata(f3, wd));
        check("busy_ready", 32'(ex_ready), 32'd0);
        check("busy_wbv", 32'(wb_valid), 32'd0);
        dmem_gnt = (k == gd);
        dmem_rvalid = (k == gd) ? 1'b0 : 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      end
      if (!we) begin
        for (int j = 0; j <= rvd; j++) begin
          @(negedge clk);
          check("wait_req", 32'(dmem_req), 32'd0);
          check("wait_wbv", 32'(wb_valid), 32'd0);
          check("wait_ready", 32'(ex_ready), 32'd0);
          dmem_rvalid = (j == rvd);
          dmem_rdata = (j == rvd) ? rdat : $urandom;
          @(posedge clk); #1;
          dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        end
      end
    end
    @(negedge clk);
    check("resp_wbv", 32'(wb_valid), 32'd1);
    check("resp_data", wb_data, exp_wb);
    check("resp_rd", 32'(wb_rd), 32'(rd));
    check("resp_mis", 32'(wb_misalign), 32'(mis));
    check("resp_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    check("post_wbv", 32'(wb_valid), 32'd0);
    check("post_ready", 32'(ex_ready), 32'd1);
    check("hold_data", wb_data, exp_wb);
  endtask

  initial begin
    logic [2:0] f3;
    logic       we;
    rst_n = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
    ex_funct3 = 3'b000; ex_rd = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ex_ready), 32'd1);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_mis", 32'(wb_misalign), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_wbdata", wb_data, 32'h0);
    check("rst_wbrd", 32'(wb_rd), 32'd0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_wdata", dmem_wdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd1, 32'hDEADBEEF, 0, 0);
    check("lw_value", wb_data, 32'hDEADBEEF);
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd2, 32'h80123456, 0, 0);
    check("lb_value", wb_data, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd3, 32'h80123456, 0, 0);
    check("lbu_value", wb_data, 32'h00000080);
    run_op(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd4, 32'h0, 0, 0);
    check("sh_wbdata", wb_data, 32'h0);
    run_op(1'b1, 3'b000, 32'h201, 32'h00000055, 5'd5, 32'h0, 5, 0);
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 32'h11223344, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_value", wb_data, 32'h0);
`else
    check("lw_mis_value", wb_data, 32'h11223344);
`endif

    // reset while the request is pending: dmem_req must drop without a clock edge
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h300; ex_rd = 5'd7;
    @(posedge clk); #1 ex_valid = 1'b0;
    @(negedge clk);
    check("rreq_req", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rreq_async_req", 32'(dmem_req), 32'd0);
    check("rreq_async_ready", 32'(ex_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rreq_ready", 32'(ex_ready), 32'd1);

    // reset while waiting for read data, then a stale rvalid
    ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h304; ex_rd = 5'd8;
    @(posedge clk); #1 ex_valid = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); #1 dmem_gnt = 1'b0;
    @(negedge clk);
    check("rwait_ready", 32'(ex_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rwait_async_ready", 32'(ex_ready), 32'd1);
    check("rwait_async_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1 dmem_rvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stale_wbv", 32'(wb_valid), 32'd0);
      check("stale_ready", 32'(ex_ready), 32'd1);
      check("stale_req", 32'(dmem_req), 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      run_op(we, f3, $urandom, $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
